// File: rtl/lcd_trace_feeder_pkg.sv
// Shared definitions for the LCD bus-trace feeder.
//   - LCD marker bytes for read and write records
//   - trace record width and bytes emitted per record
//   - feeder FSM state encoding
//   - rec_byte(): picks the idx-th output byte of a record {rw, ab[15:0], db[7:0]}
package lcd_trace_feeder_pkg;

    localparam logic [7:0] LCD_MARK_RD   = 8'h52;   // 'R'
    localparam logic [7:0] LCD_MARK_WR   = 8'h57;   // 'W'
    localparam int         TRACE_REC_W   = 25;
    localparam int         BYTES_PER_REC = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_HOLD,
        ST_RELEASE
    } feeder_state_t;

    function automatic logic [7:0] rec_byte(input logic [TRACE_REC_W-1:0] rec,
                                            input logic [1:0]             idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0: b = rec[24] ? LCD_MARK_RD : LCD_MARK_WR;
            2'd1: b = rec[23:16];
            2'd2: b = rec[15:8];
            2'd3: b = rec[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_trace_feeder_trace_fifo.sv
// DEPTH x WIDTH synchronous FIFO holding captured bus-trace records.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write request; ignored while full
//   pop             read request; ignored while empty
//   head            record at the read pointer (valid when !empty)
//   full, empty     status flags
//   count           records held, 0..DEPTH
module lcd_trace_feeder_trace_fifo
    import lcd_trace_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5,
    parameter int WIDTH = TRACE_REC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_trace_feeder.sv
// Bus-trace producer for the LCD debug path. Captures CPU bus cycles on each
// phi2 falling edge into a FIFO and, on a dump request, replays each record
// as four bytes (marker, ab hi, ab lo, db) over a 4-phase
// write_start/write_done handshake to the LCD controller.
// Ports:
//   clk, rst              board clock, synchronous active-high reset
//   phi2                  CPU phi2 (asynchronous, synchronised here)
//   ext_ab, ext_db, rw    CPU bus, stable around the phi2 fall
//   capture_en            enables sampling
//   dump                  rising edge starts a drain (taken in IDLE only)
//   init_done             LCD controller ready; gates write_start
//   write_done            LCD byte-complete acknowledge
//   write_start, data_out byte request and byte to the LCD controller
//   fifo_count            records held
//   overflow              sticky: a record was dropped on a full FIFO
//   busy                  drain in progress
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a dump edge with records present
// LOAD    | pop head record into hold_rec, byte index to 0
// REQ     | present byte, raise write_start once init_done
// HOLD    | write_start high, data_out stable until write_done
// RELEASE | write_start low, wait for write_done low, pick next byte
module lcd_trace_feeder
    import lcd_trace_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             phi2,
    input  logic [15:0]      ext_ab,
    input  logic [7:0]       ext_db,
    input  logic             rw,
    input  logic             capture_en,
    input  logic             dump,
    input  logic             init_done,
    input  logic             write_done,
    output logic             write_start,
    output logic [7:0]       data_out,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             busy
);

    localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_REC - 1);

    feeder_state_t          state;
    logic                   phi2_s1, phi2_s2, phi2_s3;
    logic                   dump_q;
    logic                   phi2_fall;
    logic                   dump_rise;
    logic                   push_req;
    logic                   pop_req;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [TRACE_REC_W-1:0] fifo_head;
    logic [TRACE_REC_W-1:0] hold_rec;
    logic [1:0]             idx;

    // phi2_s1/s2 form the synchroniser; s3 is the history bit for the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            phi2_s1 <= 1'b0;
            phi2_s2 <= 1'b0;
            phi2_s3 <= 1'b0;
            dump_q  <= 1'b0;
        end else begin
            phi2_s1 <= phi2;
            phi2_s2 <= phi2_s1;
            phi2_s3 <= phi2_s2;
            dump_q  <= dump;
        end
    end

    assign phi2_fall = phi2_s3 & ~phi2_s2;
    assign dump_rise = dump & ~dump_q;
    assign push_req  = phi2_fall & capture_en;
    assign pop_req   = (state == ST_LOAD);

    lcd_trace_feeder_trace_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .WIDTH (TRACE_REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data ({rw, ext_ab, ext_db}),
        .pop       (pop_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            write_start <= 1'b0;
            data_out    <= 8'h00;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            hold_rec    <= '0;
            idx         <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dump_rise && !fifo_empty) begin
                        state    <= ST_LOAD;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    hold_rec <= fifo_head;
                    idx      <= 2'd0;
                    state    <= ST_REQ;
                end
                ST_REQ: begin
                    data_out <= rec_byte(hold_rec, idx);
                    // write_done check keeps a stale acknowledge from
                    // completing the new byte instantly.
                    if (init_done && !write_done) begin
                        write_start <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (write_done) begin
                        write_start <= 1'b0;
                        state       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!write_done) begin
                        if (idx != IDX_LAST) begin
                            idx   <= idx + 2'd1;
                            state <= ST_REQ;
                        end else if (!fifo_empty) begin
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A drop in the same cycle as a dump start is still reported.
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_trace_feeder.sv
module tb_lcd_trace_feeder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             phi2 = 1'b0;
    logic [15:0]      ext_ab = 16'h0000;
    logic [7:0]       ext_db = 8'h00;
    logic             rw = 1'b0;
    logic             capture_en = 1'b0;
    logic             dump = 1'b0;
    logic             init_done = 1'b0;
    logic             write_done = 1'b0;
    logic             write_start;
    logic [7:0]       data_out;
    logic [CNT_W-1:0] fifo_count;
    logic             overflow;
    logic             busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    int         model_cnt = 0;
    logic       model_ovf = 1'b0;
    logic       resp_en = 1'b0;

    lcd_trace_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .phi2        (phi2),
        .ext_ab      (ext_ab),
        .ext_db      (ext_db),
        .rw          (rw),
        .capture_en  (capture_en),
        .dump        (dump),
        .init_done   (init_done),
        .write_done  (write_done),
        .write_start (write_start),
        .data_out    (data_out),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: phi2 high 4 clk, then falls and stays low 4 clk.
    task automatic capture(input logic r, input logic [15:0] ab, input logic [7:0] db);
        rw = r; ext_ab = ab; ext_db = db;
        phi2 = 1'b1;
        repeat (4) @(negedge clk);
        phi2 = 1'b0;
        if (capture_en) begin
            if (model_cnt < DEPTH) begin
                model_cnt++;
                sb.push_back(r ? 8'h52 : 8'h57);
                sb.push_back(ab[15:8]);
                sb.push_back(ab[7:0]);
                sb.push_back(db);
            end else begin
                model_ovf = 1'b1;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic start_dump();
        dump = 1'b1;
        @(negedge clk);
        dump = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_count_end"}, fifo_count, 0);
        model_cnt = 0;
    endtask

    // LCD controller model: 5-clk acknowledge delay, 4-phase handshake.
    initial begin : responder
        logic [7:0] b;
        logic [7:0] e;
        logic       stable;
        int         n;
        forever begin
            @(negedge clk);
            if (resp_en && write_start === 1'b1 && write_done === 1'b0) begin
                b = data_out;
                e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                check("byte", b, e);
                stable = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    if (write_start !== 1'b1 || data_out !== b) stable = 1'b0;
                end
                check("hold_stable", stable, 1'b1);
                write_done = 1'b1;
                n = 0;
                while (write_start !== 1'b0 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("ws_drop", write_start, 1'b0);
                write_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic ok;
        int   n;

        // 1. reset with phi2 toggling
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            phi2 = ~phi2;
        end
        phi2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_write_start", write_start, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_busy", busy, 1'b0);

        // 2. single read record
        capture_en = 1'b1;
        init_done  = 1'b1;
        resp_en    = 1'b1;
        capture(1'b1, 16'h1234, 8'hA9);
        check("read_count", fifo_count, model_cnt);
        start_dump();
        check("read_busy", busy, 1'b1);
        wait_drain("read");

        // 3. write record, plus one captured mid-drain
        capture(1'b0, 16'hFFFE, 8'h00);
        start_dump();
        capture(1'b1, 16'hBEEF, 8'h5A);
        check("mid_busy", busy, 1'b1);
        wait_drain("write");

        // 4. overflow
        for (int i = 0; i < 6; i++) capture(1'b0, 16'(i), 8'(8'h10 + i));
        check("ovf_count", fifo_count, model_cnt);
        check("ovf_flag", overflow, model_ovf);
        start_dump();
        model_ovf = 1'b0;
        check("ovf_cleared", overflow, model_ovf);
        wait_drain("ovf");

        // 5. init_done gating
        init_done = 1'b0;
        capture(1'b1, 16'hC0DE, 8'h77);
        start_dump();
        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (write_start !== 1'b0) ok = 1'b0;
        end
        check("gate_ws_low", ok, 1'b1);
        check("gate_busy", busy, 1'b1);
        init_done = 1'b1;
        n = 0;
        while (write_start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("gate_latency", (n <= 2), 1'b1);
        wait_drain("gate");

        // 6. reset mid-handshake
        resp_en = 1'b0;
        capture(1'b0, 16'hAAAA, 8'h55);
        capture(1'b1, 16'h5555, 8'hAA);
        start_dump();
        n = 0;
        while (write_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_ws_high", write_start, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ws", write_start, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_count", fifo_count, 0);
        sb.delete();
        model_cnt = 0;
        start_dump();
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (busy !== 1'b0 || write_start !== 1'b0) ok = 1'b0;
        end
        check("post_rst_dump_noop", ok, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_trace_feeder.md
Name: lcd_trace_feeder

Overview:
Bus-trace producer for the LCD debug path on the CPU bring-up board. Captures external CPU bus cycles (address, data, RW) into a small FIFO on each phi2 falling edge. On request, replays them as a byte stream into the LCD controller's writeStart/dataIn/writeDone interface. It is the writer end of that interface and sits between the CPU bus and the LCD controller in the board top.

Parameters:
DEPTH, 16, trace FIFO depth in records (power of 2, >=2)
CNT_W, 5, width of fifo_count (log2(DEPTH)+1)

Ports:
clk  input  1  board clock (USER_CLK domain)
rst  input  1  synchronous active-high reset
phi2  input  1  CPU phi2_out, asynchronous to clk
ext_ab  input  16  CPU external address bus
ext_db  input  8  CPU external data bus
rw  input  1  CPU RW (1 = read)
capture_en  input  1  level; enables sampling
dump  input  1  level or pulse; rising edge starts drain
init_done  input  1  LCD controller initialised
write_done  input  1  LCD controller byte-complete acknowledge
write_start  output  1  byte request to LCD controller
data_out  output  8  byte to LCD controller (dataIn)
fifo_count  output  CNT_W  records currently held
overflow  output  1  sticky: a sample was dropped
busy  output  1  drain in progress

Behaviour:
- Reset is synchronous, active-high, single clock clk. rst high at a clk edge sets all outputs to 0, empties the FIFO and puts the FSM in IDLE. This applies mid-handshake too: write_start is low in the cycle after rst.
- phi2 passes through a 2-flop synchroniser, then falling-edge detect. On a detected fall with capture_en=1, push record {rw, ext_ab, ext_db} (25 b), sampled in the detect cycle. Latency is 3 clk from the phi2 fall.
- ext_ab, ext_db and rw are assumed stable around the phi2 fall. clk runs at >= 8x phi2, so no extra synchroniser is needed on these buses.
- FIFO full with a push pending: the record is dropped, FIFO unchanged, overflow set to 1. overflow clears only on rst or on dump start.
- A simultaneous push and pop is legal; fifo_count is unchanged.
- dump rising-edge detect is taken in IDLE only. An edge while busy is ignored. An edge with the FIFO empty is a no-op (busy stays 0).
- FSM states: IDLE, LOAD, REQ, HOLD, RELEASE.
  - IDLE -> LOAD: on dump edge with count>0. busy=1, overflow cleared.
  - LOAD: pop the head record into a holding register; byte index := 0; go to REQ.
  - REQ: data_out := byte[idx]. Assert write_start only when init_done=1; otherwise wait in REQ. Then go to HOLD.
  - HOLD: write_start=1 and data_out held stable until write_done=1. Then drop write_start and go to RELEASE.
  - RELEASE: wait for write_done=0 (4-phase handshake). Then:
    - idx<3: idx+1, go to REQ.
    - idx==3 and FIFO non-empty: go to LOAD.
    - idx==3 and FIFO empty: go to IDLE, busy=0.
- Byte order per record: marker (0x52 'R' if rw=1, 0x57 'W' if rw=0), ab[15:8], ab[7:0], db.
- Records captured during a drain are drained in the same dump. The drain ends only when the FIFO is empty.
- write_start is never asserted while write_done=1 from the previous byte.
- The FIFO uses wrapping read/write pointers of log2(DEPTH) bits. count = pushes - pops, saturating at DEPTH.

Decomposition:
- Shared package holds:
  - LCD_MARK_RD = 8'h52, LCD_MARK_WR = 8'h57
  - TRACE_REC_W = 25
  - the FSM state encoding (IDLE/LOAD/REQ/HOLD/RELEASE)
  - BYTES_PER_REC = 4
- One sub-module: trace_fifo (DEPTH x 25b synchronous FIFO with push, pop, full, empty, count, synchronous active-high reset).
- Synchroniser and edge detects stay inline.

Test Plan:
1. Reset: rst=1 for 2 clk with phi2 toggling -> write_start=0, data_out=0x00, fifo_count=0, overflow=0, busy=0.
2. Single read capture: capture_en=1, one phi2 fall with ab=0x1234, db=0xA9, rw=1 -> fifo_count=1 within 3 clk. dump, then a write_done responder with 5-clk delay -> bytes 0x52, 0x12, 0x34, 0xA9 in order, each held stable until write_done. Ends with busy=0, count=0.
3. Write record: rw=0, ab=0xFFFE, db=0x00 -> stream 0x57, 0xFF, 0xFE, 0x00.
4. Overflow (DEPTH=4): 6 phi2 falls with ab=0x0000..0x0005 -> count=4, overflow=1. dump -> overflow=0, records 0x0000..0x0003 emitted in order.
5. init_done gating: init_done=0, one record, dump -> write_start stays 0 for 100 clk. Raise init_done -> the first byte starts within 2 clk.
6. Reset mid-handshake: rst during HOLD -> write_start=0 and busy=0 next clk, count=0. A later dump edge is a no-op.
